// File: rtl/wash_sequencer_pkg.sv
// wash_sequencer_pkg: shared definitions for the washing-machine sequencer.
//   - default durations (in 1 s ticks) and default timer width
//   - state codes 0..8 as an enum
//   - actuator bundle and the state -> actuator decode
package wash_sequencer_pkg;

  localparam int DEF_TW        = 8;
  localparam int DEF_WASH_S    = 20;
  localparam int DEF_RINSE_S   = 10;
  localparam int DEF_SPIN_S    = 15;
  localparam int DEF_DRAIN_S   = 5;
  localparam int DEF_FILL_TO_S = 30;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_WASH  = 4'd2,
    ST_DRAIN = 4'd3,
    ST_RFILL = 4'd4,
    ST_RINSE = 4'd5,
    ST_SPIN  = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAULT = 4'd8
  } state_t;

  typedef struct packed {
    logic fill_valve;
    logic drain_valve;
    logic motor_on;
    logic motor_fast;
    logic door_lock;
    logic done;
    logic fault;
  } act_t;

  // FILL through SPIN: door locked, timer running, pause honoured.
  function automatic logic in_program(state_t s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) ||
           (s == ST_RFILL) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  // Actuator decode. Pause drops valves and motor but keeps the door locked.
  function automatic act_t actuators(state_t s, logic paused);
    act_t a;
    a           = '0;
    a.door_lock = in_program(s);
    a.done      = (s == ST_DONE);
    a.fault     = (s == ST_FAULT);
    if (!paused) begin
      case (s)
        ST_FILL, ST_RFILL: a.fill_valve = 1'b1;
        ST_WASH, ST_RINSE: a.motor_on   = 1'b1;
        ST_DRAIN:          a.drain_valve = 1'b1;
        ST_SPIN: begin
          a.motor_on    = 1'b1;
          a.motor_fast  = 1'b1;
          a.drain_valve = 1'b1;
        end
        default: ;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/wash_sequencer_sec_timer.sv
// sec_timer: loadable down-counter of remaining seconds.
//   clk, rst      clock, asynchronous active-high reset
//   load,load_val load has priority over counting
//   en            count enable (tick & ~pause, gated to timed states)
//   count         current value
//   expire        en while count == 1: the last second of the state
module sec_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          expire
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - TW'(1);
    end
  end

  assign expire = en && (count == TW'(1));

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: runs one program FILL -> WASH -> DRAIN -> RFILL -> RINSE ->
// SPIN -> DONE, with pause, cancel (drain then idle) and fill-timeout FAULT.
//   clk, rst        clock, asynchronous active-high reset
//   tick            one-cycle enable per second
//   start           start level; a rising edge starts a program from IDLE
//   pause           freezes timer and actuators (door stays locked)
//   cancel          abort request
//   water_full      level sensor ending a fill
//   fill_valve .. fault   registered actuator / status outputs
//   state_o         current state code
//   secs_left       remaining ticks in the current state
// All durations must lie in 1..2^TW-1.
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int WASH_S    = DEF_WASH_S,
  parameter int RINSE_S   = DEF_RINSE_S,
  parameter int SPIN_S    = DEF_SPIN_S,
  parameter int DRAIN_S   = DEF_DRAIN_S,
  parameter int FILL_TO_S = DEF_FILL_TO_S,
  parameter int TW        = DEF_TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          pause,
  input  logic          cancel,
  input  logic          water_full,
  output logic          fill_valve,
  output logic          drain_valve,
  output logic          motor_on,
  output logic          motor_fast,
  output logic          door_lock,
  output logic          done,
  output logic          fault,
  output logic [3:0]    state_o,
  output logic [TW-1:0] secs_left
);

  state_t        state, state_nx;
  logic          abort, abort_nx;
  logic          start_q;
  act_t          act, act_nx;
  logic          load;
  logic [TW-1:0] load_val;
  logic          timer_en;
  logic          expire;
  logic          start_rise;
  logic          full_seen;

  assign start_rise = start & ~start_q;
  assign timer_en   = tick & ~pause & in_program(state);
  // A paused fill ignores the sensor.
  assign full_seen  = water_full & ~pause;

  sec_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (timer_en),
    .count    (secs_left),
    .expire   (expire)
  );

  // State register, with the registered outputs updating on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      abort   <= 1'b0;
      start_q <= 1'b0;
      act     <= '0;
    end else begin
      state   <= state_nx;
      abort   <= abort_nx;
      start_q <= start;
      act     <= act_nx;
    end
  end

  // Next state and timer load. Cancel outranks pause, which outranks
  // tick/water_full; pause needs no branch of its own because it already
  // gates both timer_en and full_seen.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    abort_nx = abort;
    load     = 1'b0;
    load_val = '0;
    if (cancel && in_program(state) && (state != ST_DRAIN)) begin
      state_nx = ST_DRAIN;
      load     = 1'b1;
      load_val = TW'(DRAIN_S);
      abort_nx = 1'b1;
    end else if (cancel && (state == ST_FAULT)) begin
      state_nx = ST_IDLE;
      load     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start_rise) begin
          state_nx = ST_FILL;
          load     = 1'b1;
          load_val = TW'(FILL_TO_S);
        end
        ST_FILL, ST_RFILL: begin
          if (full_seen) begin
            state_nx = (state == ST_FILL) ? ST_WASH : ST_RINSE;
            load     = 1'b1;
            load_val = (state == ST_FILL) ? TW'(WASH_S) : TW'(RINSE_S);
          end else if (expire) begin
            state_nx = ST_FAULT;
            load     = 1'b1;
          end
        end
        ST_WASH: if (expire) begin
          state_nx = ST_DRAIN;
          load     = 1'b1;
          load_val = TW'(DRAIN_S);
        end
        ST_DRAIN: if (expire) begin
          abort_nx = 1'b0;
          load     = 1'b1;
          if (abort) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RFILL;
            load_val = TW'(FILL_TO_S);
          end
        end
        ST_RINSE: if (expire) begin
          state_nx = ST_SPIN;
          load     = 1'b1;
          load_val = TW'(SPIN_S);
        end
        ST_SPIN: if (expire) begin
          state_nx = ST_DONE;
          load     = 1'b1;
        end
        ST_DONE: if (tick) begin
          state_nx = ST_IDLE;
          load     = 1'b1;
        end
        ST_FAULT: ;
        default: begin
          state_nx = ST_IDLE;
          abort_nx = 1'b0;
          load     = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, registered above.
  always_comb begin
    act_nx = actuators(state_nx, pause);
  end

  assign fill_valve  = act.fill_valve;
  assign drain_valve = act.drain_valve;
  assign motor_on    = act.motor_on;
  assign motor_fast  = act.motor_fast;
  assign door_lock   = act.door_lock;
  assign done        = act.done;
  assign fault       = act.fault;
  assign state_o     = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer with short durations. A program-level reference
// model (phase table of durations and successors) predicts every output.
module tb_wash_sequencer;

  localparam int TW      = 8;
  localparam int WASH    = 3;
  localparam int RINSE   = 2;
  localparam int SPIN    = 2;
  localparam int DRAIN   = 1;
  localparam int FILL_TO = 4;

  logic          clk = 1'b0;
  logic          rst, tick, start, pause, cancel, water_full;
  logic          fill_valve, drain_valve, motor_on, motor_fast, door_lock, done, fault;
  logic [3:0]    state_o;
  logic [TW-1:0] secs_left;

  int errors = 0;
  int checks = 0;

  wash_sequencer #(
    .WASH_S(WASH), .RINSE_S(RINSE), .SPIN_S(SPIN), .DRAIN_S(DRAIN),
    .FILL_TO_S(FILL_TO), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .cancel(cancel), .water_full(water_full), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .motor_on(motor_on), .motor_fast(motor_fast),
    .door_lock(door_lock), .done(done), .fault(fault), .state_o(state_o),
    .secs_left(secs_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Phase numbers are the program steps 0..8; dur/follow describe the program.
  int dur    [9] = '{0, FILL_TO, WASH, DRAIN, FILL_TO, RINSE, SPIN, 0, 0};
  int follow [9] = '{0, 2, 3, 4, 5, 6, 7, 0, 0};
  int m_phase, m_left;
  bit m_abort, m_start_q, m_paused;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_abort = 0; m_start_q = 0; m_paused = 0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_left  = dur[p];
  endtask

  task automatic model_edge();
    bit rise;
    bit is_fill;
    rise      = start && !m_start_q;
    m_start_q = start;
    m_paused  = pause;
    is_fill   = (m_phase == 1) || (m_phase == 4);
    if (cancel && m_phase inside {1, 2, 4, 5, 6}) begin
      enter(3);
      m_abort = 1;
    end else if (cancel && m_phase == 8) begin
      enter(0);
    end else if (m_phase == 0) begin
      if (rise) enter(1);
    end else if (m_phase == 7) begin
      if (tick) enter(0);
    end else if (m_phase != 8 && !pause) begin
      if (is_fill && water_full) begin
        enter(follow[m_phase]);
      end else if (tick) begin
        if (m_left > 1) m_left--;
        else if (is_fill) enter(8);
        else if (m_phase == 3) begin
          enter(m_abort ? 0 : follow[3]);
          m_abort = 0;
        end else enter(follow[m_phase]);
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    bit run;
    run = !m_paused;
    return {((m_phase == 1) || (m_phase == 4)) && run,
            ((m_phase == 3) || (m_phase == 6)) && run,
            ((m_phase == 2) || (m_phase == 5) || (m_phase == 6)) && run,
            (m_phase == 6) && run,
            (m_phase >= 1) && (m_phase <= 6),
            m_phase == 7,
            m_phase == 8,
            4'(m_phase), 8'(m_left)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {fill_valve, drain_valve, motor_on, motor_fast, door_lock, done,
            fault, state_o, secs_left};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit t);
    tick = t;
    step();
    tick = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    cyc(0);
    start = 0;
  endtask

  task automatic run_to_idle();
    water_full = 1;
    for (int i = 0; i < 100; i++) begin
      if (m_phase == 0) break;
      cyc(1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_to_idle: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    water_full = 0;
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL run_to_idle_end: state %0d expected 0", state_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; tick = 0; start = 0; pause = 0; cancel = 0; water_full = 0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    rst = 0;
    cyc(1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    int seq[$];
    int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int wash_ticks = 0, done_ticks = 0, fast_bad = 0, fill_ticks = 0;
    int s0;
    bit t, fin = 0;
    start_pulse();
    seq.push_back(int'(state_o));
    for (int i = 0; i < 400 && !fin; i++) begin
      water_full = (m_phase inside {1, 4}) && (fill_ticks >= 2);
      t  = (i % 3 == 0);
      s0 = m_phase;
      cyc(t);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL nominal_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (t && s0 == 2) wash_ticks++;
      if (t && s0 == 7) done_ticks++;
      if (t && s0 inside {1, 4}) fill_ticks++;
      if (motor_fast && state_o != 4'd6) fast_bad++;
      if (int'(state_o) != seq[$]) begin
        seq.push_back(int'(state_o));
        fill_ticks = 0;
      end
      if (state_o == 4'd0) fin = 1;
    end
    water_full = 0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL nominal_timeout: program did not return to IDLE");
    end
    checks++;
    if (seq.size() != 8) begin
      errors++;
      $display("FAIL nominal_seq_len: got %0d states expected 8", seq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (seq[k] != exp_seq[k]) begin
          errors++;
          $display("FAIL nominal_seq[%0d]: got %0d expected %0d", k, seq[k], exp_seq[k]);
          break;
        end
      end
    end
    checks++;
    if (wash_ticks != WASH) begin
      errors++;
      $display("FAIL wash_len: got %0d ticks expected %0d", wash_ticks, WASH);
    end
    checks++;
    if (done_ticks != 1) begin
      errors++;
      $display("FAIL done_len: got %0d ticks expected 1", done_ticks);
    end
    checks++;
    if (fast_bad != 0) begin
      errors++;
      $display("FAIL motor_fast_outside_spin: got %0d cycles expected 0", fast_bad);
    end
  endtask

  task automatic test_fill_timeout();
    water_full = 0;
    start_pulse();
    for (int k = 1; k <= FILL_TO; k++) begin
      cyc(0);
      cyc(1);
      if (k == FILL_TO - 1) begin
        checks++;
        if (state_o !== 4'd1) begin
          errors++;
          $display("FAIL timeout_early: state %0d expected 1 after tick %0d", state_o, k);
        end
      end
    end
    checks++;
    if ({state_o, fault, fill_valve, drain_valve, door_lock} !== {4'd8, 4'b1000}) begin
      errors++;
      $display("FAIL timeout_fault: got state %0d f%b fv%b dv%b dl%b expected 8 f1 fv0 dv0 dl0",
               state_o, fault, fill_valve, drain_valve, door_lock);
    end
    cyc(1);
    pause = 1;
    cyc(1);
    pause = 0;
    checks++;
    if (state_o !== 4'd8) begin
      errors++;
      $display("FAIL fault_sticky: state %0d expected 8", state_o);
    end
    cancel = 1;
    cyc(0);
    cancel = 0;
    checks++;
    if ({state_o, fault} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL fault_cancel: state %0d fault %b expected 0 0", state_o, fault);
    end
  endtask

  task automatic test_pause();
    start_pulse();
    cyc(1);
    cyc(1);
    water_full = 1;
    cyc(0);
    water_full = 0;
    cyc(1);
    checks++;
    if ({state_o, secs_left} !== {4'd2, 8'd2}) begin
      errors++;
      $display("FAIL pause_setup: state %0d secs %0d expected 2 2", state_o, secs_left);
    end
    pause = 1;
    for (int k = 0; k < 5; k++) begin
      cyc(0);
      cyc(1);
      checks++;
      if ({state_o, secs_left, motor_on, door_lock} !== {4'd2, 8'd2, 2'b01}) begin
        errors++;
        $display("FAIL pause_hold%0d: state %0d secs %0d motor %b lock %b expected 2 2 0 1",
                 k, state_o, secs_left, motor_on, door_lock);
      end
    end
    pause = 0;
    cyc(0);
    checks++;
    if (motor_on !== 1'b1) begin
      errors++;
      $display("FAIL pause_release_motor: got %b expected 1", motor_on);
    end
    cyc(1);
    checks++;
    if ({state_o, secs_left} !== {4'd2, 8'd1}) begin
      errors++;
      $display("FAIL pause_resume1: state %0d secs %0d expected 2 1", state_o, secs_left);
    end
    cyc(1);
    checks++;
    if (state_o !== 4'd3) begin
      errors++;
      $display("FAIL pause_resume2: state %0d expected 3", state_o);
    end
    run_to_idle();
  endtask

  task automatic test_cancel_rinse();
    bit done_seen = 0;
    water_full = 1;
    start_pulse();
    for (int i = 0; i < 50 && state_o != 4'd5; i++) begin
      cyc(1);
      done_seen |= done;
    end
    water_full = 0;
    checks++;
    if (state_o !== 4'd5) begin
      errors++;
      $display("FAIL cancel_reach_rinse: state %0d expected 5", state_o);
    end
    cancel = 1;
    cyc(0);
    cancel = 0;
    done_seen |= done;
    checks++;
    if ({state_o, secs_left, drain_valve, door_lock} !== {4'd3, 8'(DRAIN), 2'b11}) begin
      errors++;
      $display("FAIL cancel_drain: state %0d secs %0d dv %b lock %b expected 3 %0d 1 1",
               state_o, secs_left, drain_valve, door_lock, DRAIN);
    end
    cyc(1);
    done_seen |= done;
    cyc(1);
    done_seen |= done;
    checks++;
    if ({state_o, done_seen} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL cancel_idle: state %0d done_seen %b expected 0 0", state_o, done_seen);
    end
  endtask

  task automatic test_coincident();
    water_full = 1;
    start_pulse();
    cyc(0);
    water_full = 0;
    cancel = 1;
    cyc(1);
    cancel = 0;
    checks++;
    if ({state_o, secs_left} !== {4'd3, 8'(DRAIN)}) begin
      errors++;
      $display("FAIL cancel_tick_wash: state %0d secs %0d expected 3 %0d", state_o, secs_left, DRAIN);
    end
    cyc(1);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL abort_to_idle: state %0d expected 0", state_o);
    end
    start_pulse();
    for (int k = 0; k < FILL_TO - 1; k++) cyc(1);
    checks++;
    if ({state_o, secs_left} !== {4'd1, 8'd1}) begin
      errors++;
      $display("FAIL fill_last_second: state %0d secs %0d expected 1 1", state_o, secs_left);
    end
    water_full = 1;
    cyc(1);
    water_full = 0;
    checks++;
    if ({state_o, secs_left, fault} !== {4'd2, 8'(WASH), 1'b0}) begin
      errors++;
      $display("FAIL full_vs_expiry: state %0d secs %0d fault %b expected 2 %0d 0",
               state_o, secs_left, fault, WASH);
    end
    cancel = 1;
    cyc(0);
    cancel = 0;
    cyc(1);
  endtask

  task automatic test_async_reset();
    water_full = 1;
    start_pulse();
    for (int i = 0; i < 50 && state_o != 4'd6; i++) cyc(1);
    water_full = 0;
    checks++;
    if ({state_o, motor_fast} !== {4'd6, 1'b1}) begin
      errors++;
      $display("FAIL reach_spin: state %0d fast %b expected 6 1", state_o, motor_fast);
    end
    start = 1;
    #2;
    rst = 1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    start = 0;
    @(negedge clk);
    rst = 0;
    cyc(1);
    cyc(0);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle: state %0d expected 0", state_o);
    end
    start = 1;
    cyc(0);
    checks++;
    if (state_o !== 4'd1) begin
      errors++;
      $display("FAIL new_edge_starts: state %0d expected 1", state_o);
    end
    cancel = 1;
    cyc(0);
    cancel = 0;
    cyc(1);
    cyc(0);
    cyc(1);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL held_start_no_restart: state %0d expected 0", state_o);
    end
    start = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick       = ($urandom_range(2) == 0);
      pause      = ($urandom_range(11) == 0);
      cancel     = ($urandom_range(59) == 0);
      start      = ($urandom_range(6) == 0);
      water_full = ($urandom_range(5) == 0);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    tick = 0; pause = 0; cancel = 0; start = 0; water_full = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fill_timeout();
    test_pause();
    test_cancel_rinse();
    test_coincident();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
